seq_array_mult: RTL and testbench

//  Parametrised multi-cycle multiplier, successor to the 4x4 combinational array multiplier.

---
 rtl/seq_mult_pkg.sv | 24 ++
 rtl/mult_add_row.sv | 44 ++++
 rtl/seq_array_mult.sv | 136 +++++++++++++
 tb/tb_seq_array_mult.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential array multiplier.
// Sizing is parametric, so STEPS/CNT_W are provided as functions evaluated by the top.
package seq_mult_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int steps_f(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int cnt_w_f(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    // Partial product at the widest legal size; callers truncate to 2*WIDTH.
    function automatic logic [63:0] partial_product(input logic [32:0] a_mag,
                                                    input logic [3:0]  bits,
                                                    input int unsigned shift);
        logic [63:0] prod;
        prod = 64'(a_mag) * 64'(bits);
        return prod << shift;
    endfunction

endpackage

// File: rtl/mult_add_row.sv
// Combinational ripple adder row built from half/full adder cells.
// Carry out of the MSB is dropped; the accumulator width makes it always zero.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module mult_add_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    output logic [N-1:0] sum_o
);
    logic [N-1:0] carry;

    half_adder u_ha (.a_i(x_i[0]), .b_i(y_i[0]), .s_o(sum_o[0]), .c_o(carry[0]));

    for (genvar i = 1; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a_i(x_i[i]), .b_i(y_i[i]), .c_i(carry[i-1]),
            .s_o(sum_o[i]), .c_o(carry[i])
        );
    end

    logic unused_carry;
    assign unused_carry = carry[N-1];
endmodule

// File: rtl/seq_array_mult.sv
// Multi-cycle shift-and-add multiplier, BITS_PER_CYCLE multiplier bits per BUSY cycle.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module seq_array_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int STEPS = steps_f(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = cnt_w_f(STEPS);
    localparam int PW    = 2 * WIDTH;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fin_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    p_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH:0]          a_mag;
    logic [WIDTH-1:0]        b_mag;
    logic [PW-1:0]           result;
    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [PW-1:0]           pp;
    logic [PW-1:0]           acc_d;

`ifdef MULT_SIGNED_EN
    logic           sign_q;
    logic [WIDTH:0] a_ext;

    // Extra bit keeps the most-negative multiplicand exact as a magnitude.
    assign a_ext  = {a[WIDTH-1], a};
    assign a_mag  = a_ext[WIDTH] ? (~a_ext + 1'b1) : a_ext;
    assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign result = sign_q ? (~acc_q + 1'b1) : acc_q;
`else
    assign a_mag  = {1'b0, a};
    assign b_mag  = b;
    assign result = acc_q;
`endif

    assign chunk = b_q[int'(cnt_q) * BITS_PER_CYCLE +: BITS_PER_CYCLE];
    assign pp    = PW'(partial_product(33'(a_q), 4'(chunk),
                                       int'(cnt_q) * BITS_PER_CYCLE));

    mult_add_row #(.N(PW)) u_row (
        .x_i  (acc_q),
        .y_i  (pp),
        .sum_o(acc_d)
    );

    // One extra BUSY cycle after the last step so p loads from the settled acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fin_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MULT_SIGNED_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_mag;
                        b_q        <= b_mag;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        fin_q      <= 1'b0;
`ifdef MULT_SIGNED_EN
                        sign_q     <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (fin_q) begin
                        p_q         <= result;
                        fin_q       <= 1'b0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(STEPS - 1))
                            fin_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = p_q;

endmodule

// File: tb/tb_seq_array_mult.sv
// Scoreboard bench for seq_array_mult: WIDTH=4/BPC=1 and WIDTH=8/BPC=2 instances.
// Expectations follow MULT_SIGNED_EN when it is defined.
module tb_seq_array_mult;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv0 = 1'b0, ir0, ov0, or0 = 1'b0, busy0;
    logic [3:0] a0 = '0, b0 = '0;
    logic [7:0] p0;

    logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b0, busy1;
    logic [7:0]  a1 = '0, b1 = '0;
    logic [15:0] p1;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  sb0[$];
    logic [15:0] sb1[$];

    seq_array_mult #(.WIDTH(4), .BITS_PER_CYCLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .out_valid(ov0), .out_ready(or0), .p(p0), .busy(busy0)
    );

    seq_array_mult #(.WIDTH(8), .BITS_PER_CYCLE(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .p(p1), .busy(busy1)
    );

    function automatic logic [7:0] exp0(input logic [3:0] x, input logic [3:0] y);
`ifdef MULT_SIGNED_EN
        logic signed [7:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
`else
        logic [7:0] ux, uy;
        ux = x;
        uy = y;
        return ux * uy;
`endif
    endfunction

    function automatic logic [15:0] exp1(input logic [7:0] x, input logic [7:0] y);
`ifdef MULT_SIGNED_EN
        logic signed [15:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
`else
        logic [15:0] ux, uy;
        ux = x;
        uy = y;
        return ux * uy;
`endif
    endfunction

    // stall < 0 selects a random 0..3 cycle out_ready stall.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input int stall);
        int         cyc;
        int         st;
        logic [7:0] held;
        logic [7:0] e;
        cyc = 0;
        while (ir0 !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (ir0 !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", ir0);
            return;
        end
        a0  = ta;
        b0  = tb;
        iv0 = 1'b1;
        sb0.push_back(exp0(ta, tb));
        @(posedge clk); #1;
        iv0 = 1'b0;
        a0  = 4'($urandom);
        b0  = 4'($urandom);
        cyc = 0;
        while (ov0 !== 1'b1 && cyc < 20) begin
            vectors++;
            if (ir0 !== 1'b0 || busy0 !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_flags %0d*%0d: in_ready=%b busy=%b required 0/1", ta, tb, ir0, busy0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (cyc != 5) begin
            miscompares++;
            $display("FAIL latency %0d*%0d: got %0d cycles required 5", ta, tb, cyc);
        end
        if (ov0 !== 1'b1) begin
            void'(sb0.pop_front());
            return;
        end
        e = sb0.pop_front();
        vectors++;
        if (p0 !== e) begin
            miscompares++;
            $display("FAIL product %0d*%0d: p=%h required %h", ta, tb, p0, e);
        end
        held = p0;
        st   = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        or0  = 1'b0;
        repeat (st) begin
            @(posedge clk); #1;
            vectors++;
            if (ov0 !== 1'b1 || p0 !== held || ir0 !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold %0d*%0d: out_valid=%b p=%h in_ready=%b required 1 %h 0",
                         ta, tb, ov0, p0, ir0, held);
            end
        end
        or0 = 1'b1;
        @(posedge clk); #1;
        or0 = 1'b0;
        vectors++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1 || busy0 !== 1'b0 || p0 !== held) begin
            miscompares++;
            $display("FAIL after_handshake %0d*%0d: out_valid=%b in_ready=%b busy=%b p=%h required 0 1 0 %h",
                     ta, tb, ov0, ir0, busy0, p0, held);
        end
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || busy0 !== 1'b0 || p0 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_u0: in_ready=%b out_valid=%b busy=%b p=%h required 1 0 0 00", ir0, ov0, busy0, p0);
        end
        vectors++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0 || p1 !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_u1: in_ready=%b out_valid=%b busy=%b p=%h required 1 0 0 0000", ir1, ov1, busy1, p1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_max;
        run_op(4'd15, 4'd15, 0);
    endtask

    task automatic test_exhaustive;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run_op(4'(i), 4'(j), -1);
    endtask

    task automatic test_backpressure;
        run_op(4'd3, 4'd5, 6);
    endtask

    task automatic test_reset_midop;
        run_op(4'd1, 4'd1, 0);
        a0  = 4'd9;
        b0  = 4'd7;
        iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1 || busy0 !== 1'b0 || p0 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_midop: out_valid=%b in_ready=%b busy=%b p=%h required 0 1 0 00", ov0, ir0, busy0, p0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'd2, 4'd3, 0);
    endtask

    task automatic test_bpc2;
        logic [7:0]  xa[4] = '{8'd200, 8'd255, 8'd0, 8'd1};
        logic [7:0]  xb[4] = '{8'd123, 8'd255, 8'd0, 8'd255};
        logic [15:0] e;
        int          cyc;
        or1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (ir1 !== 1'b1 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            a1  = xa[k];
            b1  = xb[k];
            iv1 = 1'b1;
            sb1.push_back(exp1(xa[k], xb[k]));
            @(posedge clk); #1;
            iv1 = 1'b0;
            cyc = 0;
            while (ov1 !== 1'b1 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            vectors++;
            if (cyc != 5) begin
                miscompares++;
                $display("FAIL bpc2_latency %0d*%0d: got %0d cycles required 5", xa[k], xb[k], cyc);
            end
            e = sb1.pop_front();
            vectors++;
            if (p1 !== e || ov1 !== 1'b1) begin
                miscompares++;
                $display("FAIL bpc2_product %0d*%0d: p=%h valid=%b required %h 1", xa[k], xb[k], p1, ov1, e);
            end
            @(posedge clk); #1;
            vectors++;
            if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
                miscompares++;
                $display("FAIL bpc2_release: out_valid=%b in_ready=%b required 0 1", ov1, ir1);
            end
        end
        or1 = 1'b0;
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed;
        run_op(4'b1000, 4'd7, 1);
        run_op(4'b1000, 4'b1000, 0);
        run_op(4'd0, 4'b1111, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_max();
        test_backpressure();
        test_exhaustive();
        test_reset_midop();
        test_bpc2();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        vectors++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d/%0d left required 0/0", sb0.size(), sb1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
